core_sequencer: RTL and testbench

- Run-control sequencer for the microprocessor core (`top`).
- Generates the core's clock-enable and arbitrates the core's user-input path (`sel_usr`/`in`) between program execution and external injection requests.
- Provides run/halt/single-step control, a PC breakpoint and an executed-cycle counter.
- Sits between the board/testbench controls and the `top` instance. The core runs only when `core_en`=1.

---
 rtl/mp_pkg.sv | 14 +
 rtl/core_sequencer_if.sv | 11 +
 rtl/bp_compare.sv | 30 +++
 rtl/core_sequencer.sv | 115 +++++++++++
 tb/tb_core_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mp_pkg.sv
// Shared types and defaults for the core run-control sequencer.
package mp_pkg;

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StHalt   = 3'd1,
        StStep   = 3'd2,
        StInject = 3'd3,
        StAck    = 3'd4
    } seq_state_t;

    localparam int unsigned DefInjectCycles = 2;

endpackage

// File: rtl/core_sequencer_if.sv
// User-input injection handshake between a requester and the core sequencer.
interface core_sequencer_if #(
    parameter int unsigned BIT_WIDTH = 4
);
    logic                 usr_req;
    logic [BIT_WIDTH-2:0] usr_data;
    logic                 usr_ack;

    modport master (output usr_req, output usr_data, input usr_ack);
    modport slave  (input usr_req, input usr_data, output usr_ack);
endinterface

// File: rtl/bp_compare.sv
// PC breakpoint comparator with a skip flag that masks the first RUN cycle.
// Only built when CORE_SEQUENCER_BREAKPOINT_EN is defined.
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
module bp_compare #(
    parameter int unsigned PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_run,
    input  logic                enter_run,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] bp_addr,
    input  logic                bp_valid,
    output logic                hit
);
    logic skip_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_q <= 1'b1;
        end else if (enter_run) begin
            skip_q <= 1'b1;
        end else if (in_run) begin
            skip_q <= 1'b0;
        end
    end

    assign hit = in_run && bp_valid && (pc == bp_addr) && !skip_q;
endmodule
`endif

// File: rtl/core_sequencer.sv
// Run/halt/step/inject sequencer driving the core clock-enable and user-input mux.
// Optional breakpoint support: CORE_SEQUENCER_BREAKPOINT_EN.
module core_sequencer
    import mp_pkg::*;
#(
    parameter int unsigned BIT_WIDTH     = 4,
    parameter int unsigned PC_WIDTH      = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned INJECT_CYCLES = DefInjectCycles,
    parameter bit          AUTO_RUN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    core_sequencer_if.slave      usr,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic                 bp_valid,
    output logic                 core_en,
    output logic                 core_sel_usr,
    output logic [BIT_WIDTH-2:0] core_in,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] exec_count
);
    localparam int unsigned InjW = $clog2(INJECT_CYCLES + 1);
    localparam seq_state_t ResetState = AUTO_RUN ? StRun : StHalt;

    seq_state_t           state_q, state_d, ret_q;
    logic [InjW-1:0]      inj_cnt_q;
    logic                 en_q, sel_q, ack_q, halted_q;
    logic [BIT_WIDTH-2:0] in_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 hit;

`ifdef CORE_SEQUENCER_BREAKPOINT_EN
    bp_compare #(
        .PC_WIDTH (PC_WIDTH)
    ) u_bp_compare (
        .clk       (clk),
        .rst       (rst),
        .in_run    (state_q == StRun),
        .enter_run ((state_d == StRun) && (state_q != StRun)),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .hit       (hit)
    );
    // The breakpoint gates the enable in the cycle pc reaches bp_addr so it never executes.
    assign core_en = en_q & ~hit;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr, bp_valid, pc};
    assign hit       = 1'b0;
    assign core_en   = en_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (stop)              state_d = StHalt;
                else if (usr.usr_req)  state_d = StInject;
                else if (hit)          state_d = StHalt;
            end
            StHalt: begin
                if (stop)              state_d = StHalt;
                else if (usr.usr_req)  state_d = StInject;
                else if (step)         state_d = StStep;
                else if (start)        state_d = StRun;
            end
            StStep:   state_d = StHalt;
            StInject: begin
                if (inj_cnt_q == InjW'(INJECT_CYCLES - 1)) state_d = StAck;
            end
            StAck:    state_d = stop ? StHalt : ret_q;
            default:  state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ResetState;
            ret_q     <= StHalt;
            inj_cnt_q <= '0;
            en_q      <= 1'b0;
            sel_q     <= 1'b0;
            ack_q     <= 1'b0;
            halted_q  <= !AUTO_RUN;
            in_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= state_d inside {StRun, StStep, StInject};
            sel_q    <= (state_d == StInject);
            ack_q    <= (state_d == StAck);
            halted_q <= (state_d == StHalt);
            if (core_en && !sel_q) cnt_q <= cnt_q + CNT_WIDTH'(1);
            if ((state_d == StInject) && (state_q != StInject)) begin
                in_q      <= usr.usr_data;
                ret_q     <= state_q;
                inj_cnt_q <= '0;
            end else if (state_q == StInject) begin
                inj_cnt_q <= inj_cnt_q + InjW'(1);
            end
        end
    end

    assign core_sel_usr = sel_q;
    assign core_in      = in_q;
    assign usr.usr_ack  = ack_q;
    assign halted       = halted_q;
    assign exec_count   = cnt_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: an AUTO_RUN=1 instance for the main sequences and
// an AUTO_RUN=0 instance for reset-to-HALT and single-step.
module tb_core_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, stop = 1'b0, step = 1'b0;
    logic       h_start = 1'b0, h_step = 1'b0;
    logic       bp_valid = 1'b0;
    logic [3:0] pc = 4'd0, bp_addr = 4'd0;

    logic        en, sel, halted, h_en, h_sel, h_halted;
    logic [2:0]  cin, h_in;
    logic [15:0] cnt, h_cnt;

    core_sequencer_if #(.BIT_WIDTH(4)) run_if ();
    core_sequencer_if #(.BIT_WIDTH(4)) halt_if ();

    core_sequencer #(.AUTO_RUN(1'b1)) u_run (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .usr(run_if.slave),
        .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .core_en(en), .core_sel_usr(sel),
        .core_in(cin), .halted(halted), .exec_count(cnt)
    );

    core_sequencer #(.AUTO_RUN(1'b0)) u_halt (
        .clk(clk), .rst(rst), .start(h_start), .stop(1'b0), .step(h_step), .usr(halt_if.slave),
        .pc(pc), .bp_addr(bp_addr), .bp_valid(1'b0), .core_en(h_en), .core_sel_usr(h_sel),
        .core_in(h_in), .halted(h_halted), .exec_count(h_cnt)
    );

    typedef struct {
        logic       start, stop, step, req;
        logic [2:0] data;
        logic       en, sel, ack, halted;
        logic [2:0] in_v;
        int         inc;
    } row_t;

    row_t rows[22];
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt;
    int   n;
    logic e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          start stop step req data   en sel ack hlt  in    inc
        rows[0]  = '{0, 0, 0, 1, 3'd0,  1, 1, 0, 0, 3'd0, 1};
        rows[1]  = '{0, 0, 0, 1, 3'd0,  1, 1, 0, 0, 3'd0, 0};
        rows[2]  = '{0, 0, 0, 1, 3'd0,  0, 0, 1, 0, 3'd0, 0};
        rows[3]  = '{0, 0, 0, 0, 3'd0,  1, 0, 0, 0, 3'd0, 0};
        rows[4]  = '{0, 0, 0, 1, 3'd5,  1, 1, 0, 0, 3'd5, 1};
        rows[5]  = '{0, 1, 0, 1, 3'd5,  1, 1, 0, 0, 3'd5, 0};
        rows[6]  = '{0, 1, 0, 1, 3'd5,  0, 0, 1, 0, 3'd5, 0};
        rows[7]  = '{0, 1, 0, 0, 3'd5,  0, 0, 0, 1, 3'd5, 0};
        rows[8]  = '{1, 0, 1, 0, 3'd5,  1, 0, 0, 0, 3'd5, 0};
        rows[9]  = '{0, 0, 0, 0, 3'd5,  0, 0, 0, 1, 3'd5, 1};
        rows[10] = '{1, 0, 0, 0, 3'd5,  1, 0, 0, 0, 3'd5, 0};
        rows[11] = '{0, 1, 0, 1, 3'd3,  0, 0, 0, 1, 3'd5, 1};
        rows[12] = '{0, 0, 0, 1, 3'd3,  1, 1, 0, 0, 3'd3, 0};
        rows[13] = '{0, 0, 0, 1, 3'd3,  1, 1, 0, 0, 3'd3, 0};
        rows[14] = '{0, 0, 0, 1, 3'd3,  0, 0, 1, 0, 3'd3, 0};
        rows[15] = '{0, 0, 0, 0, 3'd3,  0, 0, 0, 1, 3'd3, 0};
        rows[16] = '{0, 0, 0, 1, 3'd6,  1, 1, 0, 0, 3'd6, 0};
        rows[17] = '{0, 0, 0, 0, 3'd6,  1, 1, 0, 0, 3'd6, 0};
        rows[18] = '{0, 0, 0, 0, 3'd6,  0, 0, 1, 0, 3'd6, 0};
        rows[19] = '{0, 0, 0, 0, 3'd6,  0, 0, 0, 1, 3'd6, 0};
        rows[20] = '{1, 0, 0, 0, 3'd6,  1, 0, 0, 0, 3'd6, 0};
        rows[21] = '{0, 0, 0, 0, 3'd6,  1, 0, 0, 0, 3'd6, 1};

        run_if.usr_req   = 1'b0;
        run_if.usr_data  = 3'd0;
        halt_if.usr_req  = 1'b0;
        halt_if.usr_data = 3'd0;

        // Reset state of both instances
        #12;
        check("rst_run_outs", {en, sel, cin, run_if.usr_ack, halted}, 7'b0);
        check("rst_run_cnt", cnt, 0);
        check("rst_halt_outs", {h_en, h_sel, h_in, halt_if.usr_ack, h_halted}, 7'b0000001);
        rst = 1'b1;

        tick();
        check("autorun_first_edge_en", en, 1);
        repeat (10) tick();
        check("autorun_cnt10", cnt, 10);
        check("autorun_not_halted", halted, 0);

        // Single step on the AUTO_RUN=0 instance
        h_step = 1'b1;
        tick();
        check("step_en", {h_en, h_halted}, 2'b10);
        h_step = 1'b0;
        tick();
        check("step_back_halt", {h_en, h_halted}, 2'b01);
        check("step_cnt1", h_cnt, 1);
        tick();
        check("step_only_once", h_en, 0);
        h_start = 1'b1;
        tick();
        check("halt_start_run", {h_en, h_halted}, 2'b10);
        h_start = 1'b0;

        exp_cnt = 14;
        for (int i = 0; i < 22; i++) begin
            start = rows[i].start;
            stop = rows[i].stop;
            step = rows[i].step;
            run_if.usr_req = rows[i].req;
            run_if.usr_data = rows[i].data;
            tick();
            exp_cnt += rows[i].inc;
            check($sformatf("row%0d_outs", i), {en, sel, run_if.usr_ack, halted, cin},
                  {rows[i].en, rows[i].sel, rows[i].ack, rows[i].halted, rows[i].in_v});
            check($sformatf("row%0d_cnt", i), cnt, exp_cnt);
        end
        start = 1'b0;

`ifdef CORE_SEQUENCER_BREAKPOINT_EN
        pc = 4'd0;
        bp_addr = 4'd5;
        bp_valid = 1'b1;
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clk);
            e = en;
            tick();
            if (e) pc = pc + 4'd1;
            n++;
        end
        check("bp_halted", halted, 1);
        check("bp_pc", pc, 5);
        check("bp_en_low", en, 0);
        start = 1'b1;
        tick();
        check("bp_resume_en", {en, halted}, 2'b10);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = en;
            tick();
            if (e) pc = pc + 4'd1;
            check($sformatf("bp_no_rehalt%0d", k), halted, 0);
        end
        check("bp_pc_past", pc, 7);
        bp_valid = 1'b0;
`else
        bp_addr = pc;
        bp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("nobp_run%0d", k), {en, halted}, 2'b10);
        end
        bp_valid = 1'b0;
`endif

        // Asynchronous reset in the middle of an injection
        run_if.usr_req = 1'b1;
        run_if.usr_data = 3'd7;
        tick();
        check("pre_rst_inject", {sel, cin}, 4'b1111);
        #3 rst = 1'b0;
        #1;
        check("midrst_outs", {en, sel, run_if.usr_ack}, 3'b000);
        check("midrst_cnt", cnt, 0);
        run_if.usr_req = 1'b0;
        #2 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("postrst_noack%0d", k), {run_if.usr_ack, sel}, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
